// File: rtl/code_converter_if.sv
// Bundle of the sample-enable, mode, input bits and registered result bits
// exchanged with the 4-bit code converter. Clock and reset stay outside.
interface code_converter_if;
  logic       en;
  logic [1:0] mode;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       x;
  logic       y;
  logic       z;
  logic       t;
  logic       err;
  logic       out_valid;

  // Stimulus side: drives the sample request, observes the result.
  modport master (
    output en, mode, a, b, c, d,
    input  x, y, z, t, err, out_valid
  );

  // Converter side: consumes the sample request, drives the result.
  modport slave (
    input  en, mode, a, b, c, d,
    output x, y, z, t, err, out_valid
  );
endinterface

// File: rtl/code_converter.sv
// Registered 4-bit code converter: binary<->Gray and BCD<->Excess-3.
// The conversion is combinational; the result, an invalid-code flag and a
// one-cycle valid strobe are registered, so outputs never follow inputs
// between clock edges.
module code_converter (
  input  logic          clk,
  input  logic          rst_n,
  code_converter_if.slave bus
);

  localparam logic [1:0] MODE_BIN2GRAY = 2'b00;
  localparam logic [1:0] MODE_GRAY2BIN = 2'b01;
  localparam logic [1:0] MODE_BCD2XS3  = 2'b10;
  localparam logic [1:0] MODE_XS32BCD  = 2'b11;

  logic [3:0] in_word;
  logic [3:0] gray_word;
  logic [3:0] bin_word;
  logic [3:0] plus3_word;
  logic [3:0] minus3_word;
  logic       bcd_ok;
  logic       xs3_ok;

  logic [3:0] conv_next;
  logic       err_next;

  logic [3:0] out_reg;
  logic       err_reg;
  logic       valid_reg;

  assign in_word = {bus.a, bus.b, bus.c, bus.d};

  // The MSB passes straight through in both Gray directions.
  assign gray_word[3] = in_word[3];
  assign bin_word[3]  = in_word[3];

  // Binary->Gray XORs adjacent bits; Gray->binary bit i is the parity of
  // all input bits from the MSB down to i. The parity form avoids a
  // ripple that feeds bin_word back into itself.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_gray_bits
      assign gray_word[gi] = in_word[gi] ^ in_word[gi+1];
      assign bin_word[gi]  = ^in_word[3:gi];
    end
  endgenerate

  // Excess-3 offsets wrap in 4 bits; the range checks below discard any
  // wrapped result before it is used.
  assign plus3_word  = in_word + 4'd3;
  assign minus3_word = in_word - 4'd3;
  assign bcd_ok      = (in_word <= 4'd9);
  assign xs3_ok      = (in_word >= 4'd3) && (in_word <= 4'd12);

  // Select the conversion for the current mode; invalid codes give 0000.
  always_comb begin
    conv_next = 4'b0000;
    err_next  = 1'b0;
    case (bus.mode)
      MODE_BIN2GRAY: conv_next = gray_word;
      MODE_GRAY2BIN: conv_next = bin_word;
      MODE_BCD2XS3: begin
        conv_next = bcd_ok ? plus3_word : 4'b0000;
        err_next  = ~bcd_ok;
      end
      MODE_XS32BCD: begin
        conv_next = xs3_ok ? minus3_word : 4'b0000;
        err_next  = ~xs3_ok;
      end
      default: begin
        conv_next = 4'b0000;
        err_next  = 1'b0;
      end
    endcase
  end

  // Capture the result when sampled; hold it otherwise, strobing valid only
  // on the cycle after a sample. Reset wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg   <= 4'b0000;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (bus.en) begin
      out_reg   <= conv_next;
      err_reg   <= err_next;
      valid_reg <= 1'b1;
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.x         = out_reg[3];
  assign bus.y         = out_reg[2];
  assign bus.z         = out_reg[1];
  assign bus.t         = out_reg[0];
  assign bus.err       = err_reg;
  assign bus.out_valid = valid_reg;

endmodule

// File: tb/tb_code_converter.sv
// Directed bench for code_converter: reset, full Gray sweeps in both
// directions, BCD/Excess-3 valid and invalid codes, enable hold and a
// mid-stream reset. Expected values are hand-computed constants.
module tb_code_converter;

  logic clk;
  logic rst_n;
  code_converter_if bus ();

  code_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Single comparison point: counts, and reports any difference.
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Drive one set of inputs, then advance past the next rising edge.
  task automatic apply(input logic [1:0] m, input logic [3:0] in_w, input logic e);
    bus.mode = m;
    {bus.a, bus.b, bus.c, bus.d} = in_w;
    bus.en = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] out_w();
    return {4'b0000, bus.x, bus.y, bus.z, bus.t};
  endfunction

  // Gray code of 0..15, written out by hand.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  typedef struct {
    logic [1:0] m;
    logic [3:0] in_w;
    logic [3:0] out_w;
    logic       err;
  } vec_t;

  // BCD->Excess-3 and Excess-3->BCD vectors, including boundaries.
  vec_t xs3_tab [12] = '{
    '{2'b10, 4'd7,  4'b1010, 1'b0},
    '{2'b10, 4'd9,  4'b1100, 1'b0},
    '{2'b10, 4'd0,  4'b0011, 1'b0},
    '{2'b10, 4'd10, 4'b0000, 1'b1},
    '{2'b10, 4'd12, 4'b0000, 1'b1},
    '{2'b11, 4'd8,  4'b0101, 1'b0},
    '{2'b11, 4'd3,  4'b0000, 1'b0},
    '{2'b11, 4'd12, 4'b1001, 1'b0},
    '{2'b11, 4'd2,  4'b0000, 1'b1},
    '{2'b11, 4'd0,  4'b0000, 1'b1},
    '{2'b11, 4'd13, 4'b0000, 1'b1},
    '{2'b11, 4'd15, 4'b0000, 1'b1}
  };

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.en = 1'b1;
    bus.mode = 2'b00;
    {bus.a, bus.b, bus.c, bus.d} = 4'b1111;

    // Reset held two clocks with en=1 and IN=1111.
    for (int i = 0; i < 2; i++) begin
      apply(2'b00, 4'b1111, 1'b1);
      check("rst_out",   out_w(), 8'h00);
      check("rst_err",   {7'd0, bus.err}, 8'h00);
      check("rst_valid", {7'd0, bus.out_valid}, 8'h00);
    end
    rst_n = 1'b1;

    // Binary->Gray sweep.
    for (int i = 0; i < 16; i++) begin
      apply(2'b00, 4'(i), 1'b1);
      check($sformatf("b2g_%0d", i), out_w(), {4'b0000, gray_tab[i]});
      check($sformatf("b2g_err_%0d", i), {7'd0, bus.err}, 8'h00);
      check($sformatf("b2g_vld_%0d", i), {7'd0, bus.out_valid}, 8'h01);
    end

    // Gray->binary: every Gray code maps back to its index.
    for (int i = 0; i < 16; i++) begin
      apply(2'b01, gray_tab[i], 1'b1);
      check($sformatf("g2b_%0d", i), out_w(), 8'(i));
      check($sformatf("g2b_err_%0d", i), {7'd0, bus.err}, 8'h00);
    end

    // Excess-3 conversions.
    for (int i = 0; i < 12; i++) begin
      apply(xs3_tab[i].m, xs3_tab[i].in_w, 1'b1);
      check($sformatf("xs3_%0d_out", i), out_w(), {4'b0000, xs3_tab[i].out_w});
      check($sformatf("xs3_%0d_err", i), {7'd0, bus.err}, {7'd0, xs3_tab[i].err});
    end

    // Load 1010, then hold with en=0 while IN changes.
    apply(2'b10, 4'b0111, 1'b1);
    check("load_out", out_w(), 8'h0A);
    check("load_vld", {7'd0, bus.out_valid}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      apply(2'(i), 4'(i * 5 + 1), 1'b0);
      check($sformatf("hold_out_%0d", i), out_w(), 8'h0A);
      check($sformatf("hold_err_%0d", i), {7'd0, bus.err}, 8'h00);
      check($sformatf("hold_vld_%0d", i), {7'd0, bus.out_valid}, 8'h00);
    end

    // Error flag also holds while en=0.
    apply(2'b11, 4'b1110, 1'b1);
    check("err_set", {7'd0, bus.err}, 8'h01);
    apply(2'b00, 4'b0000, 1'b0);
    check("err_hold", {7'd0, bus.err}, 8'h01);

    // Reload 1010 then pulse reset for one clock with en=1.
    apply(2'b10, 4'b0111, 1'b1);
    check("reload_out", out_w(), 8'h0A);
    rst_n = 1'b0;
    apply(2'b10, 4'b0111, 1'b1);
    check("midrst_out", out_w(), 8'h00);
    check("midrst_vld", {7'd0, bus.out_valid}, 8'h00);
    rst_n = 1'b1;

    // First conversion after release.
    apply(2'b00, 4'b1011, 1'b1);
    check("post_rst_out", out_w(), 8'h0E);
    check("post_rst_vld", {7'd0, bus.out_valid}, 8'h01);

    // Outputs stay put between edges while inputs move.
    {bus.a, bus.b, bus.c, bus.d} = 4'b0001;
    bus.mode = 2'b01;
    #2;
    check("no_comb_path", out_w(), 8'h0E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
